// File: rtl/red_pitaya_pfd_block_gen.sv
// Phase-frequency detector: qualified s1/s2 edges step a W-bit integrator up/down.
// Define PFD_INPUT_SYNC_EN to put 2-flop synchronizers on s1_i/s2_i.
module red_pitaya_pfd_block_gen #(
  parameter int OUTBITS = 14,
  parameter int ISR     = 0,
  parameter int PSCBITS = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      s1_i,
  input  logic                      s2_i,
  input  logic [1:0]                edge_sel_i,
  input  logic [PSCBITS-1:0]        psc1_i,
  input  logic [PSCBITS-1:0]        psc2_i,
  input  logic                      mode_i,
  input  logic                      clear_i,
  output logic signed [OUTBITS-1:0] integral_o,
  output logic                      sat_o,
  output logic                      ovf_o
);
  localparam int W = OUTBITS + ISR;
  localparam logic [W-1:0]       MAXV    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]       MINV    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]       ONE     = W'(1);
  localparam logic [PSCBITS-1:0] PSC_ONE = PSCBITS'(1);

  logic s1_in, s2_in;

`ifdef PFD_INPUT_SYNC_EN
  // Sync flops are part of the post-reset disarm window, hence 3 cycles.
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [1:0] s1_sync_q, s2_sync_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_sync_q <= '0;
      s2_sync_q <= '0;
    end else begin
      s1_sync_q <= {s1_sync_q[0], s1_i};
      s2_sync_q <= {s2_sync_q[0], s2_i};
    end
  end
  assign s1_in = s1_sync_q[1];
  assign s2_in = s2_sync_q[1];
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign s1_in = s1_i;
  assign s2_in = s2_i;
`endif

  logic [1:0]         arm_q, arm_d;
  logic               last1_q, last1_d, last2_q, last2_d;
  logic [PSCBITS-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [W-1:0]       integ_q, integ_d;
  logic               sat_q, sat_d, ovf_q, ovf_d;
  logic               armed, e1, e2, v1, v2, up, dn;

  always_comb begin
    armed   = (arm_q == ARM_CYC);
    arm_d   = armed ? arm_q : arm_q + 2'd1;
    last1_d = s1_in ^ edge_sel_i[0];
    last2_d = s2_in ^ edge_sel_i[1];
    e1      = armed & last1_d & ~last1_q;
    e2      = armed & last2_d & ~last2_q;

    // '>=' so a psc lowered mid-count fires on the next edge instead of wrapping.
    v1 = 1'b0;
    cnt1_d = cnt1_q;
    if (e1) begin
      if (cnt1_q >= psc1_i) begin
        v1 = 1'b1;
        cnt1_d = '0;
      end else begin
        cnt1_d = cnt1_q + PSC_ONE;
      end
    end
    v2 = 1'b0;
    cnt2_d = cnt2_q;
    if (e2) begin
      if (cnt2_q >= psc2_i) begin
        v2 = 1'b1;
        cnt2_d = '0;
      end else begin
        cnt2_d = cnt2_q + PSC_ONE;
      end
    end

    up = v1 & ~v2;
    dn = v2 & ~v1;
    integ_d = integ_q;
    ovf_d   = 1'b0;
    if (up) begin
      if (integ_q == MAXV) begin
        if (mode_i) begin
          integ_d = MINV;
          ovf_d   = 1'b1;
        end
      end else begin
        integ_d = integ_q + ONE;
      end
    end else if (dn) begin
      if (integ_q == MINV) begin
        if (mode_i) begin
          integ_d = MAXV;
          ovf_d   = 1'b1;
        end
      end else begin
        integ_d = integ_q - ONE;
      end
    end
    sat_d = ~mode_i & ((integ_d == MAXV) | (integ_d == MINV));

    // Edge samplers keep running through clear so no false edge follows it.
    if (clear_i) begin
      integ_d = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
      ovf_d   = 1'b0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_q   <= '0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      integ_q <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      integ_q <= integ_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign integral_o = integ_q[W-1:ISR];
  assign sat_o      = sat_q;
  assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_red_pitaya_pfd_block_gen.sv
// Directed bench for red_pitaya_pfd_block_gen (default build, OUTBITS=14, ISR=0).
module tb_red_pitaya_pfd_block_gen;
  logic              clk = 1'b0;
  logic              rst, s1, s2, mode, clr;
  logic [1:0]        esel;
  logic [7:0]        psc1, psc2;
  logic signed [13:0] integ;
  logic              sat, ovf;
  int                n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  red_pitaya_pfd_block_gen dut (
    .clk_i(clk), .rst_i(rst), .s1_i(s1), .s2_i(s2), .edge_sel_i(esel),
    .psc1_i(psc1), .psc2_i(psc2), .mode_i(mode), .clear_i(clr),
    .integral_o(integ), .sat_o(sat), .ovf_o(ovf)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1(input int n);
    for (int i = 0; i < n; i++) begin
      s1 = 1'b1; tick();
      s1 = 1'b0; tick();
    end
  endtask

  task automatic do_clear();
    clr = 1'b1; tick();
    clr = 1'b0; tick();
  endtask

  initial begin
    int seen;
    rst = 1'b1; s1 = 1'b1; s2 = 1'b0; mode = 1'b0; clr = 1'b0;
    esel = 2'b00; psc1 = 8'd0; psc2 = 8'd0;
    repeat (3) tick();
    chk("rst_integ", integ, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovf", ovf, 0);

    // s1 held high across reset release: no spurious count
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_integ", integ, 0);
    end

    // s1 period 10, s2 period 20, both rise together every 20 cycles
    s1 = 1'b0; s2 = 1'b0; tick();
    do_clear();
    for (int t = 0; t < 200; t++) begin
      s1 = ((t % 10) < 5);
      s2 = ((t % 20) < 10);
      tick();
    end
    chk("freq_diff", integ, 10);

    // identical waveforms cancel
    s1 = 1'b0; s2 = 1'b0; tick();
    do_clear();
    chk("clear_integ", integ, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      s1 = 1'b1; s2 = 1'b1; tick(); seen |= int'(sat | ovf);
      s1 = 1'b0; s2 = 1'b0; tick(); seen |= int'(sat | ovf);
    end
    chk("same_integ", integ, 0);
    chk("same_flags", seen, 0);

    // saturation at +max
    pulse1(9000);
    chk("sat_integ", integ, 8191);
    chk("sat_flag", sat, 1);
    s2 = 1'b1; tick(); s2 = 1'b0; tick();
    chk("unsat_integ", integ, 8190);
    chk("unsat_flag", sat, 0);
    pulse1(1);
    chk("resat_integ", integ, 8191);

    // wrap mode
    mode = 1'b1;
    s1 = 1'b1; tick();
    chk("wrap_integ", integ, -8192);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_sat", sat, 0);
    s1 = 1'b0; tick();
    chk("wrap_ovf_clr", ovf, 0);
    chk("wrap_hold", integ, -8192);
    s2 = 1'b1; tick();
    chk("wrapdn_integ", integ, 8191);
    chk("wrapdn_ovf", ovf, 1);
    s2 = 1'b0; tick();
    chk("wrapdn_ovf_clr", ovf, 0);

    // prescaler and clear restart
    mode = 1'b0; psc1 = 8'd3;
    do_clear();
    pulse1(8);
    chk("psc_8", integ, 2);
    pulse1(2);
    chk("psc_10", integ, 2);
    do_clear();
    chk("psc_clear", integ, 0);
    pulse1(3);
    chk("psc_restart3", integ, 0);
    pulse1(1);
    chk("psc_restart4", integ, 1);
    psc1 = 8'd0;

    // falling-edge polarity on s1 (clear removes the select-change edge)
    esel = 2'b01; tick();
    do_clear();
    s1 = 1'b1; tick();
    chk("fall_rise", integ, 0);
    s1 = 1'b0; tick();
    chk("fall_fall", integ, 1);

    // mid-run reset with s1 high: disarm suppresses the edge
    esel = 2'b00;
    s1 = 1'b1; rst = 1'b1; tick();
    chk("midrst_integ", integ, 0);
    rst = 1'b0; tick(); tick();
    chk("midrst_noedge", integ, 0);
    s1 = 1'b0; tick(); s1 = 1'b1; tick();
    chk("midrst_edge", integ, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
